// File: rtl/atm_bank_arbiter.sv
// atm_bank_arbiter
//   Round-robin arbiter in front of a shared single-port account-balance
//   memory. Each accepted request runs as one atomic read-check-write
//   sequence. Only one transaction is in flight at a time.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  per-terminal handshake; transfer on valid & ready
//   req_op/acc/dst/amt   flattened per-terminal payload (terminal i at slice i)
//   resp_valid           one-cycle completion pulse to the owning terminal
//   resp_status          000 OK, 001 INSUFFICIENT, 010 BAD_ACC, 011 SELF_XFER,
//                        100 OVERFLOW, 101 BAD_OP
//   resp_balance         source-account balance after the operation
//   busy, current_state  FSM monitor outputs
//   mem_*                external balance memory, one-cycle read latency
module atm_bank_arbiter #(
    parameter int NUM_TERM = 2,
    parameter int NUM_ACC  = 4,
    parameter int ACC_W    = 4,
    parameter int AMT_W    = 6,
    parameter int BAL_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_TERM-1:0]       req_valid,
    output logic [NUM_TERM-1:0]       req_ready,
    input  logic [3*NUM_TERM-1:0]     req_op,
    input  logic [ACC_W*NUM_TERM-1:0] req_acc,
    input  logic [ACC_W*NUM_TERM-1:0] req_dst,
    input  logic [AMT_W*NUM_TERM-1:0] req_amt,
    output logic [NUM_TERM-1:0]       resp_valid,
    output logic [2:0]                resp_status,
    output logic [BAL_W-1:0]          resp_balance,
    output logic                      busy,
    output logic [3:0]                current_state,
    output logic [ACC_W-1:0]          mem_addr,
    output logic                      mem_re,
    output logic                      mem_we,
    output logic [BAL_W-1:0]          mem_wdata,
    input  logic [BAL_W-1:0]          mem_rdata
);

    localparam int PTR_W = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;

    localparam logic [2:0] OP_WD   = 3'b000;
    localparam logic [2:0] OP_DEP  = 3'b001;
    localparam logic [2:0] OP_XFER = 3'b011;

    localparam logic [2:0] ST_OK    = 3'b000;
    localparam logic [2:0] ST_INSUF = 3'b001;
    localparam logic [2:0] ST_BADAC = 3'b010;
    localparam logic [2:0] ST_SELF  = 3'b011;
    localparam logic [2:0] ST_OVF   = 3'b100;
    localparam logic [2:0] ST_BADOP = 3'b101;

    localparam logic [ACC_W:0]   NUM_ACC_X  = (ACC_W+1)'(NUM_ACC);
    localparam logic [PTR_W:0]   NUM_TERM_X = (PTR_W+1)'(NUM_TERM);
    localparam logic [PTR_W-1:0] LAST_TERM  = PTR_W'(NUM_TERM - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        RD_A  = 4'd1,
        CAP_A = 4'd2,
        RD_B  = 4'd3,
        CAP_B = 4'd4,
        EXEC  = 4'd5,
        WR_A  = 4'd6,
        WR_B  = 4'd7,
        RESP  = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [2:0]        op_q, op_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  dst_q, dst_d;
    logic [AMT_W-1:0]  amt_q, amt_d;
    logic [BAL_W-1:0]  bal_a_q, bal_a_d;
    logic [BAL_W-1:0]  bal_b_q, bal_b_d;
    logic [BAL_W-1:0]  new_b_q, new_b_d;
    logic [2:0]        status_q, status_d;
    // Holds the response balance; on an OK write it is also the new A value.
    logic [BAL_W-1:0]  resp_bal_q, resp_bal_d;

    // Unpacked per-terminal payload views.
    logic [2:0]       op_arr  [NUM_TERM];
    logic [ACC_W-1:0] acc_arr [NUM_TERM];
    logic [ACC_W-1:0] dst_arr [NUM_TERM];
    logic [AMT_W-1:0] amt_arr [NUM_TERM];

    for (genvar g = 0; g < NUM_TERM; g++) begin : g_unpack
        assign op_arr[g]  = req_op[3*g +: 3];
        assign acc_arr[g] = req_acc[ACC_W*g +: ACC_W];
        assign dst_arr[g] = req_dst[ACC_W*g +: ACC_W];
        assign amt_arr[g] = req_amt[AMT_W*g +: AMT_W];
    end

    // Round-robin search: first valid terminal at or above the pointer, with wrap.
    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W:0]   cand_sum;
    logic [PTR_W-1:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_TERM; i++) begin
            cand_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (cand_sum >= NUM_TERM_X) begin
                cand_sum = cand_sum - NUM_TERM_X;
            end
            cand = cand_sum[PTR_W-1:0];
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Arithmetic one bit wider than a balance so overflow/borrow is visible.
    logic [BAL_W:0] amt_x, bal_a_x, a_minus, a_plus, b_plus;
    logic           insuf;

    assign amt_x   = (BAL_W+1)'(amt_q);
    assign bal_a_x = {1'b0, bal_a_q};
    assign a_minus = bal_a_x - amt_x;
    assign a_plus  = bal_a_x + amt_x;
    assign b_plus  = {1'b0, bal_b_q} + amt_x;
    assign insuf   = (amt_x > bal_a_x);

    logic [2:0]       in_op;
    logic [ACC_W-1:0] in_acc, in_dst;

    assign in_op  = op_arr[win_idx];
    assign in_acc = acc_arr[win_idx];
    assign in_dst = dst_arr[win_idx];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        op_d       = op_q;
        acc_d      = acc_q;
        dst_d      = dst_q;
        amt_d      = amt_q;
        bal_a_d    = bal_a_q;
        bal_b_d    = bal_b_q;
        new_b_d    = new_b_q;
        status_d   = status_q;
        resp_bal_d = resp_bal_q;

        req_ready    = '0;
        resp_valid   = '0;
        resp_status  = status_q;
        resp_balance = resp_bal_q;
        mem_addr     = '0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = '0;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    owner_d = win_idx;
                    ptr_d   = (win_idx == LAST_TERM) ? '0 : win_idx + 1'b1;
                    op_d    = in_op;
                    acc_d   = in_acc;
                    dst_d   = in_dst;
                    amt_d   = amt_arr[win_idx];
                    // Rejection priority: op, then account range, then self-transfer.
                    if (in_op > OP_XFER) begin
                        status_d   = ST_BADOP;
                        resp_bal_d = '0;
                        state_d    = RESP;
                    end else if (({1'b0, in_acc} >= NUM_ACC_X) ||
                                 ((in_op == OP_XFER) && ({1'b0, in_dst} >= NUM_ACC_X))) begin
                        status_d   = ST_BADAC;
                        resp_bal_d = '0;
                        state_d    = RESP;
                    end else if ((in_op == OP_XFER) && (in_dst == in_acc)) begin
                        status_d   = ST_SELF;
                        resp_bal_d = '0;
                        state_d    = RESP;
                    end else begin
                        state_d = RD_A;
                    end
                end
            end
            RD_A: begin
                mem_re   = 1'b1;
                mem_addr = acc_q;
                state_d  = CAP_A;
            end
            CAP_A: begin
                bal_a_d = mem_rdata;
                state_d = (op_q == OP_XFER) ? RD_B : EXEC;
            end
            RD_B: begin
                mem_re   = 1'b1;
                mem_addr = dst_q;
                state_d  = CAP_B;
            end
            CAP_B: begin
                bal_b_d = mem_rdata;
                state_d = EXEC;
            end
            EXEC: begin
                status_d   = ST_OK;
                resp_bal_d = bal_a_q;
                state_d    = RESP;
                unique case (op_q)
                    OP_WD: begin
                        if (insuf) begin
                            status_d = ST_INSUF;
                        end else begin
                            resp_bal_d = a_minus[BAL_W-1:0];
                            state_d    = WR_A;
                        end
                    end
                    OP_DEP: begin
                        if (a_plus[BAL_W]) begin
                            status_d = ST_OVF;
                        end else begin
                            resp_bal_d = a_plus[BAL_W-1:0];
                            state_d    = WR_A;
                        end
                    end
                    OP_XFER: begin
                        if (insuf) begin
                            status_d = ST_INSUF;
                        end else if (b_plus[BAL_W]) begin
                            status_d = ST_OVF;
                        end else begin
                            resp_bal_d = a_minus[BAL_W-1:0];
                            new_b_d    = b_plus[BAL_W-1:0];
                            state_d    = WR_A;
                        end
                    end
                    default: ;
                endcase
            end
            WR_A: begin
                mem_we    = 1'b1;
                mem_addr  = acc_q;
                mem_wdata = resp_bal_q;
                state_d   = (op_q == OP_XFER) ? WR_B : RESP;
            end
            WR_B: begin
                mem_we    = 1'b1;
                mem_addr  = dst_q;
                mem_wdata = new_b_q;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid[owner_q] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // No handshake, response or memory access while reset is asserted.
        if (rst) begin
            req_ready    = '0;
            resp_valid   = '0;
            resp_status  = '0;
            resp_balance = '0;
            mem_addr     = '0;
            mem_re       = 1'b0;
            mem_we       = 1'b0;
            mem_wdata    = '0;
        end
    end

    assign busy          = (state_q != IDLE);
    assign current_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            dst_q      <= '0;
            amt_q      <= '0;
            bal_a_q    <= '0;
            bal_b_q    <= '0;
            new_b_q    <= '0;
            status_q   <= '0;
            resp_bal_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            dst_q      <= dst_d;
            amt_q      <= amt_d;
            bal_a_q    <= bal_a_d;
            bal_b_q    <= bal_b_d;
            new_b_q    <= new_b_d;
            status_q   <= status_d;
            resp_bal_q <= resp_bal_d;
        end
    end

endmodule

// File: doc/atm_bank_arbiter.md
Name: atm_bank_arbiter

Overview:
Shared-account-bank controller for multi-terminal ATM builds. It round-robin arbitrates between NUM_TERM terminal front-ends, each running its own ATM FSM, and sequences every transaction as an atomic read-check-write on one single-port balance memory. Supported operations are withdraw, deposit, balance and transfer. Each transaction returns a status code and the resulting balance to the requesting terminal.

Parameters:
NUM_TERM, 2, number of requesting terminals (2..8)
NUM_ACC, 4, number of valid accounts; ids >= NUM_ACC do not exist
ACC_W, 4, account id width
AMT_W, 6, transaction amount width
BAL_W, 8, balance width (unsigned)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_TERM  per-terminal request valid
req_ready  out  NUM_TERM  per-terminal accept; a request transfers when valid&ready
req_op  in  3*NUM_TERM  per-terminal op: 000 withdraw, 001 deposit, 010 balance, 011 transfer; others illegal
req_acc  in  ACC_W*NUM_TERM  source/own account
req_dst  in  ACC_W*NUM_TERM  transfer destination account
req_amt  in  AMT_W*NUM_TERM  amount, zero-extended to BAL_W
resp_valid  out  NUM_TERM  one-cycle completion pulse to the owning terminal
resp_status  out  3  000 OK, 001 INSUFFICIENT, 010 BAD_ACC, 011 SELF_XFER, 100 OVERFLOW, 101 BAD_OP
resp_balance  out  BAL_W  source-account balance after the operation
busy  out  1  high whenever state != IDLE
current_state  out  4  FSM state encoding, for debug/monitor
mem_addr  out  ACC_W  balance memory address
mem_re  out  1  read enable; mem_rdata is valid on the next cycle
mem_we  out  1  write enable
mem_wdata  out  BAL_W  write data
mem_rdata  in  BAL_W  read data

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_status=000, resp_balance=0, busy=0, current_state=IDLE, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, RR pointer=0.
- States: IDLE=0, RD_A=1, CAP_A=2, RD_B=3, CAP_B=4, EXEC=5, WR_A=6, WR_B=7, RESP=8.
- IDLE: req_ready is high only for the winner, and only in IDLE. The winner is the first valid terminal scanning from the RR pointer upward with wrap. On acceptance (cycle T) the block latches op/acc/dst/amt and sets pointer = (winner+1) mod NUM_TERM.
- Rejection at latch (no memory access; go straight to RESP, response at T+1), in this priority order:
  - illegal op -> BAD_OP
  - acc >= NUM_ACC, or (transfer and dst >= NUM_ACC) -> BAD_ACC
  - transfer with dst == acc -> SELF_XFER
- Rejected responses return resp_balance=0.
- RD_A: mem_re=1, mem_addr=acc. CAP_A: bal_a <= mem_rdata. Then RD_B if the op is transfer, otherwise EXEC.
- RD_B: mem_re=1, mem_addr=dst. CAP_B: bal_b <= mem_rdata.
- EXEC: compute the result and status.
  - Withdraw: amt > bal_a -> INSUFFICIENT; else bal_a - amt.
  - Deposit: bal_a + amt > 2^BAL_W - 1 -> OVERFLOW; else the sum.
  - Transfer: INSUFFICIENT has priority over OVERFLOW, where OVERFLOW means bal_b + amt overflows.
  - Balance: no change, no write.
  - Amount 0 is legal: OK, and the unchanged value is written.
- Writes: on OK for withdraw, deposit or transfer, go to WR_A (mem_we=1, addr=acc, wdata=new A). Transfer then goes to WR_B (addr=dst, wdata=new B). Errors and balance ops go EXEC -> RESP with no write.
- RESP: resp_valid[owner]=1 for exactly one cycle, with status and balance held valid in that cycle. resp_balance is the new A on OK, otherwise the unchanged bal_a. Then IDLE.
- Latency from acceptance cycle T to resp_valid:
  - balance: T+4
  - withdraw/deposit OK: T+5; withdraw/deposit error: T+4
  - transfer OK: T+8; transfer error: T+6
  - latch rejection: T+1
- Only one transaction is in flight at a time. A new acceptance can happen at the earliest in the cycle after RESP.
- Requests that lose arbitration must hold valid and payload; the block never drops them.
- A requester deasserting valid before acceptance withdraws its request; this is legal.
- Arithmetic: amounts are zero-extended; compare/add is done at BAL_W+1 bits. No saturation; overflow is an error.
- rst mid-operation: the FSM returns to IDLE the next edge and the in-flight response is discarded. mem_re and mem_we are gated by !rst, so there is no memory access in any reset cycle. A reset between WR_A and WR_B leaves the transfer torn; this is acceptable because the balance memory is reinitialised by the same system reset.
- Balance memory is owned outside this block; the block never infers storage for balances.

Test Plan:
1. Preload acc3=30, acc2=0. T0 term0 balance acc3 -> resp_valid[0] at T+4, OK, 30; mem_we never asserted.
2. Term0 withdraw 12 from acc3 -> write addr3 data 18 at T+4; resp at T+5 OK 18. Then withdraw 30 -> INSUFFICIENT, balance 18, no write, resp at T+4.
3. Transfer 5 acc3->acc2 -> writes (3,13) at T+6 and (2,5) at T+7; resp at T+8 OK 13. Then dst=7 -> BAD_ACC at T+1; dst=3 -> SELF_XFER at T+1; op=100 -> BAD_OP at T+1.
4. Preload acc1=200, deposit 63 -> OVERFLOW, balance 200, no write. Deposit 55 -> OK 255.
5. After reset, both terminals hold balance requests continuously for three transactions -> grants in order 0,1,0. The waiting terminal keeps req_ready=0 while busy=1.
6. Assert rst for 1 cycle while in RD_B of a transfer -> no mem_we, no resp_valid. The next cycle is IDLE, req_ready rises for term0, and memory is unchanged.
